// File: rtl/mic_sampler_pkg.sv
// Shared types and elaboration helpers for the mic sampler family.
package mic_sampler_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, STREAM} stream_state_t;

   function automatic int calc_div(input int clk_hz, input int sample_rate);
      return clk_hz / sample_rate;
   endfunction

   // Legal configuration: at least two clocks per sample, 1 <= HOP <= N.
   function automatic bit cfg_ok(input int clk_hz, input int sample_rate,
                                 input int hop, input int n);
      return (calc_div(clk_hz, sample_rate) >= 2) && (hop >= 1) && (hop <= n);
   endfunction

   // Offset-binary midpoint; XOR with it converts to two's complement.
   function automatic longint unsigned offset_bias(input int width);
      return 64'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/mic_frame_sampler_if.sv
// Frame stream from the sampler to the FFT front end (ready/valid).
interface mic_frame_sampler_if #(
   parameter int WIDTH    = 12,
   parameter int N        = 256,
   parameter int CHANNELS = 1
);
   logic                      frame_valid;
   logic                      frame_ready;
   logic [CHANNELS*WIDTH-1:0] frame_data;
   logic [$clog2(N)-1:0]      frame_idx;
   logic                      frame_last;

   modport master (output frame_valid, frame_data, frame_idx, frame_last, input frame_ready);
   modport slave  (input frame_valid, frame_data, frame_idx, frame_last, output frame_ready);
endinterface

// File: rtl/sample_strobe_gen.sv
// Sample-rate strobe: one-cycle tick every CLK_HZ/SAMPLE_RATE clocks while enabled.
module sample_strobe_gen
   import mic_sampler_pkg::*;
#(
   parameter int CLK_HZ      = 10000000,
   parameter int SAMPLE_RATE = 5000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic tick
);
   localparam int DIV = calc_div(CLK_HZ, SAMPLE_RATE);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   if (DIV < 2) begin : g_bad_div
      $error("sample_strobe_gen: CLK_HZ/SAMPLE_RATE must be at least 2");
   end

   logic [CW-1:0] cnt;

   assign tick = enable && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               cnt <= '0;
      else if (!enable || tick) cnt <= '0;
      else                      cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/mic_frame_sampler.sv
// Multi-channel ADC sampler emitting overlapping N-sample frames every HOP samples.
// Optional MIC_FRAME_SAMPLER_SIGNED_EN: frame_data converted to two's complement.
module mic_frame_sampler
   import mic_sampler_pkg::*;
#(
   parameter int WIDTH       = 12,
   parameter int N           = 256,
   parameter int CHANNELS    = 1,
   parameter int CLK_HZ      = 10000000,
   parameter int SAMPLE_RATE = 5000,
   parameter int HOP         = 256
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic [CHANNELS*WIDTH-1:0] adc_data,
   input  logic                      adc_valid,
   output logic                      sample_tick,
   mic_frame_sampler_if.master       frm,
   output logic                      overrun
);
   localparam int DW    = CHANNELS * WIDTH;
   localparam int DEPTH = 2 * N;
   localparam int AW    = $clog2(DEPTH);
   localparam int IW    = $clog2(N);
   localparam int FW    = $clog2(N + 1);
   localparam int HW    = $clog2(HOP + 1);

   localparam logic [FW-1:0] FILL_FULL = FW'(N);
   localparam logic [FW-1:0] FILL_PRE  = FW'(N - 1);
   localparam logic [HW-1:0] HOP_PRE   = HW'(HOP - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
   localparam logic [IW-1:0] IDX_PRE   = IW'(N - 2);
   localparam logic [AW-1:0] N_A       = AW'(N);

   if (!cfg_ok(CLK_HZ, SAMPLE_RATE, HOP, N)) begin : g_bad_cfg
      $error("mic_frame_sampler: need CLK_HZ/SAMPLE_RATE >= 2 and 1 <= HOP <= N");
   end

`ifdef MIC_FRAME_SAMPLER_SIGNED_EN
   localparam logic [WIDTH-1:0] BIAS = WIDTH'(offset_bias(WIDTH));
   localparam logic [DW-1:0]    OUT_MASK = {CHANNELS{BIAS}};
`else
   localparam logic [DW-1:0]    OUT_MASK = '0;
`endif

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] held, wr_data, rd_q;
   logic [AW-1:0] wr_ptr, base, base_next, rd_addr;
   logic [IW-1:0] idx;
   logic [FW-1:0] fill;
   logic [HW-1:0] hop_cnt;
   logic          valid_q, last_q;
   logic          trigger, beat, final_beat;
   stream_state_t state;

   sample_strobe_gen #(.CLK_HZ(CLK_HZ), .SAMPLE_RATE(SAMPLE_RATE)) u_strobe (
      .clk(clk), .rst_n(rst_n), .enable(enable), .tick(sample_tick)
   );

   // A conversion landing on the tick cycle is stored directly.
   assign wr_data   = adc_valid ? adc_data : held;
   assign base_next = wr_ptr + AW'(1) - N_A;
   assign beat      = (state == STREAM) && valid_q && frm.frame_ready;
   assign final_beat = beat && (idx == IDX_LAST);
   assign rd_addr   = base + AW'(idx) + AW'(beat);

   always_comb begin
      trigger = 1'b0;
      if (sample_tick) begin
         if (fill == FILL_PRE)                           trigger = 1'b1;
         else if (fill == FILL_FULL && hop_cnt == HOP_PRE) trigger = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         held <= '0;
      else if (adc_valid) held <= adc_data;
   end

   always_ff @(posedge clk) begin
      if (sample_tick) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         fill    <= '0;
         hop_cnt <= '0;
      end else begin
         if (sample_tick) wr_ptr <= wr_ptr + 1'b1;
         if (!enable) begin
            fill    <= '0;
            hop_cnt <= '0;
         end else if (sample_tick) begin
            if (fill != FILL_FULL) fill <= fill + 1'b1;
            if (trigger)                hop_cnt <= '0;
            else if (fill == FILL_FULL) hop_cnt <= hop_cnt + 1'b1;
         end
      end
   end

   // Sign conversion sits in front of the read register so reset leaves data at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        rd_q <= '0;
      else if (state == FETCH || beat)   rd_q <= mem[rd_addr] ^ OUT_MASK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         base    <= '0;
         idx     <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (!enable)                                    overrun <= 1'b0;
         else if (trigger && state != IDLE && !final_beat) overrun <= 1'b1;

         case (state)
            IDLE: if (trigger) begin
               state <= FETCH;
               base  <= base_next;
            end
            FETCH: begin
               state   <= STREAM;
               valid_q <= 1'b1;
               idx     <= '0;
               last_q  <= 1'b0;
            end
            STREAM: if (beat) begin
               if (final_beat) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  idx     <= '0;
                  if (trigger) begin
                     state <= FETCH;
                     base  <= base_next;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  idx    <= idx + 1'b1;
                  last_q <= (idx == IDX_PRE);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign frm.frame_valid = valid_q;
   assign frm.frame_data  = rd_q;
   assign frm.frame_idx   = idx;
   assign frm.frame_last  = last_q;
endmodule
